ucaspian_step_sched: RTL

Time-step scheduler for the uCaspian core. It accumulates run-length requests from the packet decoder into a target time and watches the done flags of every pipeline stage (dendrite, neuron, axon, fire dispatch, synapses, output drain). It issues one `next_step` pulse per network time step when the core has settled, and reports the new time to the host through a pending/sent handshake. It replaces the ad-hoc time counter in the core with an explicit FSM.

---
 rtl/ucaspian_pkg.sv | 16 +
 rtl/ucaspian_step_sched_if.sv | 33 +++
 rtl/ucaspian_sat_acc.sv | 47 ++++
 rtl/ucaspian_step_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ucaspian_pkg.sv
// rtl/ucaspian_pkg.sv - shared types and constants for the uCaspian step scheduler
// Purpose: FSM state type and default widths used by the scheduler, its
// accumulator and its bus interface.
package ucaspian_pkg;

  localparam int TIME_W_DEFAULT = 32;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    STEP    = 2'd2,
    HOLDOFF = 2'd3
  } step_state_t;

endpackage

// File: rtl/ucaspian_step_sched_if.sv
// rtl/ucaspian_step_sched_if.sv - target and time-report handshake bundle
// Purpose: groups the decoder-facing target handshake and the host-facing
// time report.
// Signals:
//   target_value/target_vld/target_rdy : run-length request handshake
//   time_current/time_remaining        : completed steps, target not yet reached
//   time_update/time_sent              : pending-report handshake to host
// Modports: master = decoder/host side, slave = scheduler side.
interface ucaspian_step_sched_if
  import ucaspian_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEFAULT
);

  logic [7:0]        target_value;
  logic              target_vld;
  logic              target_rdy;
  logic [TIME_W-1:0] time_current;
  logic              time_remaining;
  logic              time_update;
  logic              time_sent;

  modport master (
    output target_value, target_vld, time_sent,
    input  target_rdy, time_current, time_remaining, time_update
  );

  modport slave (
    input  target_value, target_vld, time_sent,
    output target_rdy, time_current, time_remaining, time_update
  );

endinterface

// File: rtl/ucaspian_sat_acc.sv
// rtl/ucaspian_sat_acc.sv - saturating accumulator with 8-bit increment
// Purpose: W-bit register that adds an 8-bit value on add_en_i, clamping at
// all-ones instead of wrapping. clr_i has priority over add_en_i.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr_i           : synchronous clear to zero
//   add_en_i        : add add_val_i this cycle
//   add_val_i [7:0] : increment
//   value_o   [W]   : registered value
//   next_o    [W]   : value after the current edge (for registered compares)
module ucaspian_sat_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         add_en_i,
  input  logic [7:0]   add_val_i,
  output logic [W-1:0] value_o,
  output logic [W-1:0] next_o
);

  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {{(W-7){1'b0}}, add_val_i};
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_en_i) begin
      acc_d = sum[W] ? '1 : sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign value_o = acc_q;
  assign next_o  = acc_d;

endmodule

// File: rtl/ucaspian_step_sched.sv
// rtl/ucaspian_step_sched.sv - network time-step scheduler for the uCaspian core
// Purpose: accumulates a target time from run-length requests and fires one
// next_step pulse per time step once every pipeline stage has been idle for
// SETTLE_CYC cycles, the host has acknowledged the previous step and time is
// still below target.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   clear_act, clear_config   : synchronous clear of all run state
//   stage_done [STAGES]       : per-stage idle flags
//   bus (slave)               : target handshake and time report to host
//   next_step                 : one-cycle step pulse to all stages
//   core_active               : run in progress or stages busy
module ucaspian_step_sched
  import ucaspian_pkg::*;
#(
  parameter int STAGES      = 6,
  parameter int TIME_W      = TIME_W_DEFAULT,
  parameter int SETTLE_CYC  = 2,
  parameter int HOLDOFF_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_act,
  input  logic                 clear_config,
  input  logic [STAGES-1:0]    stage_done,
  ucaspian_step_sched_if.slave bus,
  output logic                 next_step,
  output logic                 core_active
);

  logic              clr;
  logic              all_done;
  logic              tgt_rdy;
  logic              tgt_hs;
  logic              go;

  step_state_t       state_q, state_d;
  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              next_step_q, next_step_d;
  logic              time_update_q, time_update_d;
  logic              time_remaining_q, time_remaining_d;
  logic [TIME_W-1:0] target_q, target_d;
  logic [TIME_W-1:0] time_cur_q, time_cur_d;

  assign clr      = clear_act | clear_config;
  assign all_done = &stage_done;
  // reset_n gates the ready so the decoder sees no acceptance while in reset
  assign tgt_rdy  = reset_n & ~clr;
  assign tgt_hs   = bus.target_vld & tgt_rdy;
  // step condition; time_update blocks until the host has taken the last step
  assign go       = time_remaining_q & all_done & ~time_update_q;

  ucaspian_sat_acc #(.W(TIME_W)) u_target (
    .clk       (clk),
    .rst_n     (reset_n),
    .clr_i     (clr),
    .add_en_i  (tgt_hs),
    .add_val_i (bus.target_value),
    .value_o   (target_q),
    .next_o    (target_d)
  );

  // time_current never exceeds target, so the clamp never engages here
  ucaspian_sat_acc #(.W(TIME_W)) u_time (
    .clk       (clk),
    .rst_n     (reset_n),
    .clr_i     (clr),
    .add_en_i  (state_q == STEP),
    .add_val_i (8'd1),
    .value_o   (time_cur_q),
    .next_o    (time_cur_d)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      IDLE: begin
        settle_cnt_d = '0;
        // the first qualifying cycle already counts toward the settle window
        if (go) begin
          if (SETTLE_CYC <= 1) begin
            state_d = STEP;
          end else begin
            state_d      = SETTLE;
            settle_cnt_d = CNT_W'(1);
          end
        end
      end
      SETTLE: begin
        if (!go) begin
          state_d      = IDLE;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d      = STEP;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      STEP: begin
        state_d    = HOLDOFF;
        hold_cnt_d = '0;
      end
      HOLDOFF: begin
        // stages still show stale done flags right after the step; ignore them
        if (hold_cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d      = IDLE;
      settle_cnt_d = '0;
      hold_cnt_d   = '0;
    end
  end

  always_comb begin
    next_step_d      = (state_d == STEP);
    time_remaining_d = (target_d > time_cur_d);
    time_update_d    = time_update_q;
    if (clr) begin
      time_update_d = 1'b0;
    end else if (state_q == STEP) begin
      time_update_d = 1'b1;
    end else if (bus.time_sent) begin
      time_update_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      settle_cnt_q     <= '0;
      hold_cnt_q       <= '0;
      next_step_q      <= 1'b0;
      time_update_q    <= 1'b0;
      time_remaining_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      settle_cnt_q     <= settle_cnt_d;
      hold_cnt_q       <= hold_cnt_d;
      next_step_q      <= next_step_d;
      time_update_q    <= time_update_d;
      time_remaining_q <= time_remaining_d;
    end
  end

  assign bus.target_rdy     = tgt_rdy;
  assign bus.time_current   = time_cur_q;
  assign bus.time_remaining = time_remaining_q;
  assign bus.time_update    = time_update_q;
  assign next_step          = next_step_q;
  assign core_active        = reset_n & ~clr &
                              (time_remaining_q | ~all_done | (state_q != IDLE));

endmodule
